load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 176 +++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store sequencer in front of a byte-addressed memory.
// Accepts one access at a time, validates it (funct3, alignment, optional range),
// drives a single-cycle memory command, then returns extended load data or a fault.
//
// Ports
//   clock, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready     : request handshake (ready only while idle)
//   req_write, req_funct3   : store/load select and RV32I width/sign code
//   req_addr, req_wdata     : byte address and store data
//   resp_valid              : one-cycle completion pulse
//   resp_rdata              : extended load data (0 for stores and faults)
//   resp_fault, resp_cause  : rejection flag and cause (1 misaligned, 2 funct3, 3 range)
//   mem_address, mem_width  : memory byte address and byte count (1/2/4)
//   mem_write_en            : memory write strobe (high for one cycle per store)
//   mem_data_in             : unshifted store data
//   mem_data_out            : right-aligned read data, valid the cycle after sampling
//
// Configuration: define LSU_RANGE_CHECK_EN to fault (cause 3) on any nonzero
// req_addr[31:ADDR_BITS]; otherwise upper address bits are ignored (wrap).
module load_store_unit #(
    parameter int unsigned ADDR_BITS = 10
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [2:0]           req_funct3,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    output logic [31:0]          resp_rdata,
    output logic                 resp_fault,
    output logic [1:0]           resp_cause,
    output logic [ADDR_BITS-1:0] mem_address,
    output logic [3:0]           mem_width,
    output logic                 mem_write_en,
    output logic [31:0]          mem_data_in,
    input  logic [31:0]          mem_data_out
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        accept_c;
    logic [1:0]  cause_c;
    logic        bad_funct3_c;
    logic        misaligned_c;
    logic        range_bad_c;
    logic [2:0]  ld_funct3;
    logic [31:0] load_ext_c;

    // Upper address bits either fault or are silently dropped.
`ifdef LSU_RANGE_CHECK_EN
    assign range_bad_c = |req_addr[31:ADDR_BITS];
`else
    assign range_bad_c = 1'b0;
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS];
`endif

    // Request validation: funct3 legality outranks alignment, which outranks range.
    always_comb begin
        bad_funct3_c = 1'b0;
        misaligned_c = 1'b0;
        cause_c      = 2'd0;
        if (req_write) begin
            bad_funct3_c = (req_funct3 > 3'b010);
        end else begin
            bad_funct3_c = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
        end
        misaligned_c = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        if (bad_funct3_c) begin
            cause_c = 2'd2;
        end else if (misaligned_c) begin
            cause_c = 2'd1;
        end else if (range_bad_c) begin
            cause_c = 2'd3;
        end
    end

    // Next-state logic; faults skip the memory phases entirely.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    accept_c   = 1'b1;
                    state_next = (cause_c != 2'd0) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE:   state_next = mem_write_en ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_next = S_RESP;
            S_RESP:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Load data extension from the funct3 captured at accept.
    always_comb begin
        load_ext_c = mem_data_out;
        case (ld_funct3)
            3'b000:  load_ext_c = {{24{mem_data_out[7]}}, mem_data_out[7:0]};
            3'b001:  load_ext_c = {{16{mem_data_out[15]}}, mem_data_out[15:0]};
            3'b100:  load_ext_c = {24'd0, mem_data_out[7:0]};
            3'b101:  load_ext_c = {16'd0, mem_data_out[15:0]};
            default: load_ext_c = mem_data_out;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Registered handshake and response strobes track the next state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
        end else begin
            req_ready  <= (state_next == S_IDLE);
            resp_valid <= (state_next == S_RESP);
        end
    end

    // Memory command and response datapath.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_address  <= '0;
            mem_width    <= 4'd4;
            mem_write_en <= 1'b0;
            mem_data_in  <= 32'd0;
            ld_funct3    <= 3'd0;
            resp_rdata   <= 32'd0;
            resp_fault   <= 1'b0;
            resp_cause   <= 2'd0;
        end else begin
            if (accept_c) begin
                resp_rdata <= 32'd0;
                resp_cause <= cause_c;
                resp_fault <= (cause_c != 2'd0);
                if (cause_c == 2'd0) begin
                    mem_address  <= req_addr[ADDR_BITS-1:0];
                    mem_data_in  <= req_wdata;
                    mem_write_en <= req_write;
                    ld_funct3    <= req_funct3;
                    case (req_funct3[1:0])
                        2'b00:   mem_width <= 4'd1;
                        2'b01:   mem_width <= 4'd2;
                        default: mem_width <= 4'd4;
                    endcase
                end
            end
            if (state == S_ISSUE) begin
                mem_write_en <= 1'b0;
            end
            if (state == S_CAPTURE) begin
                resp_rdata <= load_ext_c;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized self-checking bench for load_store_unit.
// A byte-array memory sits on the mem_* port; a separate reference byte array
// plus arithmetic rules predicts responses, latencies and the final memory image.
module tb_load_store_unit;

    localparam int unsigned ADDR_BITS = 10;
    localparam int unsigned MEM_BYTES = 1 << ADDR_BITS;

    logic                 clock;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_write;
    logic [2:0]           req_funct3;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic [31:0]          resp_rdata;
    logic                 resp_fault;
    logic [1:0]           resp_cause;
    logic [ADDR_BITS-1:0] mem_address;
    logic [3:0]           mem_width;
    logic                 mem_write_en;
    logic [31:0]          mem_data_in;
    logic [31:0]          mem_data_out;

    int total = 0;
    int bad   = 0;

    logic [7:0] env_mem [MEM_BYTES];
    logic [7:0] ref_mem [MEM_BYTES];

    load_store_unit #(.ADDR_BITS(ADDR_BITS)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_fault   (resp_fault),
        .resp_cause   (resp_cause),
        .mem_address  (mem_address),
        .mem_width    (mem_width),
        .mem_write_en (mem_write_en),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment memory: synchronous write of mem_width bytes, registered 4-byte read.
    always @(posedge clock) begin
        if (mem_write_en) begin
            for (int i = 0; i < int'(mem_width); i++) begin
                env_mem[(int'(mem_address) + i) % MEM_BYTES] <= mem_data_in[8*i +: 8];
            end
        end
        mem_data_out <= {env_mem[(int'(mem_address) + 3) % MEM_BYTES],
                         env_mem[(int'(mem_address) + 2) % MEM_BYTES],
                         env_mem[(int'(mem_address) + 1) % MEM_BYTES],
                         env_mem[int'(mem_address)]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] ref_cause(input logic w, input logic [2:0] f3,
                                             input logic [31:0] addr);
        int size;
        if (w ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 2'd2;
        size = 1 << f3[1:0];
        if ((addr % 32'(size)) != 0) return 2'd1;
`ifdef LSU_RANGE_CHECK_EN
        if (addr >= 32'(MEM_BYTES)) return 2'd3;
`endif
        return 2'd0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr);
        int size;
        int a;
        logic [31:0] v;
        size = 1 << f3[1:0];
        a = int'(addr % 32'(MEM_BYTES));
        v = 32'd0;
        for (int i = 0; i < size; i++) begin
            v = v | (32'(ref_mem[(a + i) % MEM_BYTES]) << (8 * i));
        end
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] d);
        int size;
        int a;
        size = 1 << f3[1:0];
        a = int'(addr % 32'(MEM_BYTES));
        for (int i = 0; i < size; i++) ref_mem[(a + i) % MEM_BYTES] = d[8*i +: 8];
    endtask

    // One full transaction; call just after a negedge with the unit idle.
    task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] d, output logic [31:0] got);
        logic [1:0]  ec;
        logic [31:0] er;
        int          exp_lat;
        int          lat;
        int          wen;
        ec = ref_cause(w, f3, addr);
        er = (ec == 2'd0 && !w) ? ref_load(f3, addr) : 32'd0;
        exp_lat = (ec != 2'd0) ? 1 : (w ? 2 : 3);
        check("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = addr; req_wdata = d;
        @(posedge clock);
        lat = 0;
        wen = 0;
        while (lat < 8) begin
            @(negedge clock);
            req_valid = 1'b0;
            lat++;
            if (mem_write_en) wen++;
            if (resp_valid) break;
        end
        got = resp_rdata;
        check("latency", 32'(lat), 32'(exp_lat));
        check("wen_cycles", 32'(wen), (ec == 2'd0 && w) ? 32'd1 : 32'd0);
        check("fault", 32'(resp_fault), 32'(ec != 2'd0));
        check("cause", 32'(resp_cause), 32'(ec));
        check("rdata", resp_rdata, er);
        @(negedge clock);
        check("pulse_len", 32'(resp_valid), 32'd0);
        check("rdata_hold", resp_rdata, er);
        if (ec == 2'd0 && w) ref_store(f3, addr, d);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [2:0]  f3;
        logic        w;
        int          acc;
        int          rsp;
        int          viol;
        int          diffs;

        for (int i = 0; i < int'(MEM_BYTES); i++) begin
            env_mem[i] = 8'($urandom);
            ref_mem[i] = env_mem[i];
        end
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0;

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(resp_valid), 32'd0);
        check("rst_addr", 32'(mem_address), 32'd0);
        check("rst_width", 32'(mem_width), 32'd4);
        check("rst_wen", 32'(mem_write_en), 32'd0);
        check("rst_din", mem_data_in, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_cause", 32'(resp_cause), 32'd0);
        reset = 1'b1;

        // Byte loads with sign/zero extension.
        {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'h8899AABB;
        {env_mem[259], env_mem[258], env_mem[257], env_mem[256]} = 32'h8899AABB;
        do_access(1'b0, 3'b000, 32'h101, 32'd0, got);
        check("lb_const", got, 32'hFFFFFFAA);
        do_access(1'b0, 3'b100, 32'h101, 32'd0, got);
        check("lbu_const", got, 32'h000000AA);

        // Halfword store then word load.
        do_access(1'b1, 3'b001, 32'h102, 32'h0000CAFE, got);
        do_access(1'b0, 3'b010, 32'h100, 32'd0, got);
        check("lw_after_sh", got, 32'hCAFEAABB);

        // Misaligned and illegal funct3.
        do_access(1'b0, 3'b010, 32'h103, 32'd0, got);
        do_access(1'b1, 3'b011, 32'h100, 32'h12345678, got);

        // Out-of-range / wrap.
        do_access(1'b0, 3'b010, 32'h400, 32'd0, got);
`ifdef LSU_RANGE_CHECK_EN
        check("lw_400", got, 32'd0);
`else
        check("lw_400", got, {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]});
`endif

        // Reset during ISSUE of a store aborts it.
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        @(posedge clock);
        #1;
        check("abort_issued", 32'(mem_write_en), 32'd1);
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        check("abort_wen", 32'(mem_write_en), 32'd0);
        check("abort_addr", 32'(mem_address), 32'd0);
        check("abort_width", 32'(mem_width), 32'd4);
        @(posedge clock);
        #1;
        check("abort_noresp", 32'(resp_valid), 32'd0);
        @(negedge clock);
        check("abort_word", {env_mem[19], env_mem[18], env_mem[17], env_mem[16]},
              {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
        reset = 1'b1;
        // First accept on the first posedge after release.
        do_access(1'b0, 3'b010, 32'h10, 32'd0, got);

        // Randomized accesses.
        for (int n = 0; n < 300; n++) begin
            w  = 1'($urandom);
            f3 = 3'($urandom);
            if ($urandom_range(0, 3) != 0) f3 = {f3[2], 1'b0, f3[0]} | 3'(w ? 0 : 0);
            a  = 32'($urandom_range(0, MEM_BYTES - 1));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFFFC00);
            do_access(w, f3, a, $urandom, got);
        end

        // req_valid held high: accepts only when idle, one response per accept.
        req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
        acc = 0; rsp = 0; viol = 0;
        for (int c = 0; c < 40; c++) begin
            if (req_ready && (acc != rsp)) viol++;
            if (resp_valid) rsp++;
            if (req_ready) acc++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready && (acc != rsp)) viol++;
            if (resp_valid) rsp++;
            @(negedge clock);
        end
        check("held_accepts", 32'(acc), 32'd10);
        check("held_resps", 32'(rsp), 32'(acc));
        check("held_ready", 32'(viol), 32'd0);
        check("held_rdata", resp_rdata, ref_load(3'b010, 32'h100));

        diffs = 0;
        for (int i = 0; i < int'(MEM_BYTES); i++) if (env_mem[i] !== ref_mem[i]) diffs++;
        check("mem_image", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
